multi_sprite_core: RTL and testbench

Video-slot core that overlays up to N_SPRITES independent 32×32 sprites on the incoming pixel stream. Each sprite has its own pattern RAM, position, enable, mirror flags and signed per-frame velocity. Positions are advanced automatically once per video frame with screen wrap-around. It sits in the video pipeline between the upstream stream source and downstream cores, driven by the same frame counter and video slot bus as the other sprite cores.

---
 rtl/sprite_pkg.sv | 43 ++++
 rtl/multi_sprite_core_slot.sv | 61 ++++++
 rtl/multi_sprite_core.sv | 133 +++++++++++++
 tb/tb_multi_sprite_core.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the multi-sprite overlay core: register map, ctrl
// bit positions, per-sprite register struct and the motion wrap helper.
package sprite_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_X0     = 3'd1;
    localparam logic [2:0] REG_Y0     = 3'd2;
    localparam logic [2:0] REG_VX     = 3'd3;
    localparam logic [2:0] REG_VY     = 3'd4;
    localparam logic [2:0] REG_BYPASS = 3'd7;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_HFLIP = 1;
    localparam int CTRL_VFLIP = 2;
    localparam int CTRL_MOVE  = 3;

    typedef struct packed {
        logic               enable;
        logic               hflip;
        logic               vflip;
        logic               move_en;
        logic [10:0]        x0;
        logic [10:0]        y0;
        logic signed [7:0]  vx;
        logic signed [7:0]  vy;
    } sprite_regs_t;

    // Single-step wrap: only correct while pos < res, which software guarantees.
    function automatic logic [10:0] wrap_step(input logic [10:0] pos,
                                              input logic [7:0]  vel,
                                              input logic [10:0] res);
        logic signed [11:0] s;
        logic signed [11:0] r;
        r = $signed({1'b0, res});
        s = $signed({1'b0, pos}) + $signed({{4{vel[7]}}, vel});
        if (s < 12'sd0)
            s = s + r;
        else if (s >= r)
            s = s - r;
        return s[10:0];
    endfunction

endpackage

// File: rtl/multi_sprite_core_slot.sv
// One sprite: pattern RAM, hit test and flip-aware read address. Outputs are
// registered together so hit_o lines up with the synchronous RAM data.
module sprite_slot #(
    parameter int CD        = 12,
    parameter int SIZE_LOG2 = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic [2*SIZE_LOG2-1:0]   waddr_i,
    input  logic [CD-1:0]            wdata_i,
    input  logic                     enable_i,
    input  logic                     hflip_i,
    input  logic                     vflip_i,
    input  logic [10:0]              x0_i,
    input  logic [10:0]              y0_i,
    input  logic [10:0]              x_i,
    input  logic [10:0]              y_i,
    output logic                     hit_o,
    output logic [CD-1:0]            pix_o
);
    localparam int AW   = 2 * SIZE_LOG2;
    localparam int EDGE = 1 << SIZE_LOG2;

    logic [CD-1:0]        mem [2**AW];
    logic [SIZE_LOG2-1:0] col, row, col_f, row_f;
    logic [11:0]          x_end, y_end;
    logic                 hit;
    logic                 hit_q;
    logic [CD-1:0]        pix_q;

    // Low bits of the offset equal the difference of the low bits.
    assign col   = x_i[SIZE_LOG2-1:0] - x0_i[SIZE_LOG2-1:0];
    assign row   = y_i[SIZE_LOG2-1:0] - y0_i[SIZE_LOG2-1:0];
    assign col_f = hflip_i ? ~col : col;
    assign row_f = vflip_i ? ~row : row;

    // 12-bit compares: a sprite near the right/bottom edge clips, never wraps.
    assign x_end = {1'b0, x0_i} + 12'(EDGE);
    assign y_end = {1'b0, y0_i} + 12'(EDGE);
    assign hit   = enable_i
                 && ({1'b0, x_i} >= {1'b0, x0_i}) && ({1'b0, x_i} < x_end)
                 && ({1'b0, y_i} >= {1'b0, y0_i}) && ({1'b0, y_i} < y_end);

    always_ff @(posedge clk) begin
        if (we_i)
            mem[waddr_i] <= wdata_i;
        pix_q <= mem[{row_f, col_f}];
    end

    always_ff @(posedge clk) begin
        if (reset)
            hit_q <= 1'b0;
        else
            hit_q <= hit;
    end

    assign hit_o = hit_q;
    assign pix_o = pix_q;

endmodule

// File: rtl/multi_sprite_core.sv
// Sprite overlay core: register file, per-frame motion, slot decode and the
// two-stage priority compositor in front of the downstream pixel stream.
module multi_sprite_core
    import sprite_pkg::*;
#(
    parameter int CD        = 12,
    parameter int N_SPRITES = 4,
    parameter int SIZE_LOG2 = 5,
    parameter int KEY_COLOR = 0,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x_i,
    input  logic [10:0]   y_i,
    input  logic          cs_i,
    input  logic          write_i,
    input  logic [13:0]   addr_i,
    input  logic [31:0]   wr_data_i,
    input  logic [CD-1:0] si_rgb_i,
    output logic [CD-1:0] so_rgb_o
);
    localparam int AW = 2 * SIZE_LOG2;

    sprite_regs_t [N_SPRITES-1:0]         regs_q, regs_d;
    logic                                 bypass_q, bypass_d;
    logic                                 tick_cond, tick_cond_q, tick;
    logic                                 wr_en, ram_wr, reg_wr;
    logic [2:0]                           reg_spr, reg_sel;
    logic [N_SPRITES-1:0]                 hit;
    logic [N_SPRITES-1:0][CD-1:0]         pix;
    logic [CD-1:0]                        si_q, out_d, so_rgb_q;
    logic                                 unused_wdata;

    assign wr_en   = cs_i & write_i;
    assign ram_wr  = wr_en & ~addr_i[13];
    assign reg_wr  = wr_en &  addr_i[13];
    assign reg_spr = addr_i[6:4];
    assign reg_sel = addr_i[2:0];
    assign unused_wdata = ^wr_data_i;

    // Edge-detected so a stalled frame counter still yields one move per frame.
    assign tick_cond = (x_i == 11'd0) && (y_i == 11'(V_RES));
    assign tick      = tick_cond & ~tick_cond_q;

    always_comb begin
        regs_d   = regs_q;
        bypass_d = bypass_q;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (tick && regs_q[i].move_en) begin
                regs_d[i].x0 = wrap_step(regs_q[i].x0, regs_q[i].vx, 11'(H_RES));
                regs_d[i].y0 = wrap_step(regs_q[i].y0, regs_q[i].vy, 11'(V_RES));
            end
            // CPU write applied last so it overrides a same-cycle move.
            if (reg_wr && reg_spr == 3'(i)) begin
                case (reg_sel)
                    REG_CTRL: begin
                        regs_d[i].enable  = wr_data_i[CTRL_EN];
                        regs_d[i].hflip   = wr_data_i[CTRL_HFLIP];
                        regs_d[i].vflip   = wr_data_i[CTRL_VFLIP];
                        regs_d[i].move_en = wr_data_i[CTRL_MOVE];
                    end
                    REG_X0:  regs_d[i].x0 = wr_data_i[10:0];
                    REG_Y0:  regs_d[i].y0 = wr_data_i[10:0];
                    REG_VX:  regs_d[i].vx = wr_data_i[7:0];
                    REG_VY:  regs_d[i].vy = wr_data_i[7:0];
                    default: ;
                endcase
            end
        end
        if (reg_wr && reg_sel == REG_BYPASS)
            bypass_d = wr_data_i[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q      <= '0;
            bypass_q    <= 1'b0;
            tick_cond_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            bypass_q    <= bypass_d;
            tick_cond_q <= tick_cond;
        end
    end

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_slot
        sprite_slot #(
            .CD        (CD),
            .SIZE_LOG2 (SIZE_LOG2)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .we_i     (ram_wr && (addr_i[12:10] == 3'(g))),
            .waddr_i  (addr_i[AW-1:0]),
            .wdata_i  (wr_data_i[CD-1:0]),
            .enable_i (regs_q[g].enable),
            .hflip_i  (regs_q[g].hflip),
            .vflip_i  (regs_q[g].vflip),
            .x0_i     (regs_q[g].x0),
            .y0_i     (regs_q[g].y0),
            .x_i      (x_i),
            .y_i      (y_i),
            .hit_o    (hit[g]),
            .pix_o    (pix[g])
        );
    end

    // Walk from lowest priority up so the lowest opaque index wins.
    always_comb begin
        out_d = si_q;
        if (!bypass_q) begin
            for (int i = N_SPRITES - 1; i >= 0; i--) begin
                if (hit[i] && pix[i] != CD'(KEY_COLOR))
                    out_d = pix[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            si_q     <= '0;
            so_rgb_q <= '0;
        end else begin
            si_q     <= si_rgb_i;
            so_rgb_q <= out_d;
        end
    end

    assign so_rgb_o = so_rgb_q;

endmodule

// File: tb/tb_multi_sprite_core.sv
// Directed bench for multi_sprite_core: table-driven pixel vectors plus
// hand-written sequences for flips, priority, motion, bypass and reset.
module tb_multi_sprite_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y;
    logic        cs, write;
    logic [13:0] addr;
    logic [31:0] wr_data;
    logic [11:0] si_rgb;
    logic [11:0] so_rgb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_sprite_core dut (
        .clk       (clk),
        .reset     (reset),
        .x_i       (x),
        .y_i       (y),
        .cs_i      (cs),
        .write_i   (write),
        .addr_i    (addr),
        .wr_data_i (wr_data),
        .si_rgb_i  (si_rgb),
        .so_rgb_o  (so_rgb)
    );

    typedef struct {
        logic [10:0] vx;
        logic [10:0] vy;
        logic [11:0] si;
        logic [11:0] exp;
    } vec_t;

    vec_t tv[8];

    function automatic logic [13:0] pa(input int s, input int row, input int col);
        return 14'((s << 10) | (row << 5) | col);
    endfunction

    function automatic logic [13:0] ra(input int s, input int r);
        return 14'(32'h2000 | (s << 4) | r);
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %03h expected %03h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    // Present a coordinate, let it cross both stages, then compare.
    task automatic pix(input string name, input int px, input int py,
                       input logic [11:0] si, input logic [11:0] exp);
        @(negedge clk);
        x = 11'(px); y = 11'(py); si_rgb = si;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(name, so_rgb, exp);
    endtask

    task automatic tick_frame();
        @(negedge clk);
        x = 11'd0; y = 11'd480;
        @(negedge clk);
        x = 11'd1000; y = 11'd1000;
    endtask

    logic [11:0] hist[$];

    initial begin
        reset = 1'b1; cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
        x = 11'd1000; y = 11'd1000; si_rgb = 12'h000;
        repeat (3) @(posedge clk);
        #1 chk("reset_out", so_rgb, 12'h000);
        @(negedge clk) reset = 1'b0;

        // Clear all four pattern RAMs, one write per cycle.
        @(negedge clk);
        cs = 1'b1; write = 1'b1; wr_data = 32'h0;
        for (int i = 0; i < 4096; i++) begin
            addr = 14'(i);
            @(negedge clk);
        end
        cs = 1'b0; write = 1'b0;

        wr(pa(0, 3, 5), 32'hF00);
        wr(pa(0, 0, 31), 32'h0A1);
        wr(pa(0, 31, 31), 32'h0B2);
        wr(ra(0, 1), 100);
        wr(ra(0, 2), 50);
        wr(ra(0, 0), 32'h1);

        tv[0] = '{105, 53, 12'h123, 12'hF00};
        tv[1] = '{ 99, 53, 12'h123, 12'h123};
        tv[2] = '{132, 53, 12'h456, 12'h456};
        tv[3] = '{131, 81, 12'h456, 12'h0B2};
        tv[4] = '{100, 49, 12'h777, 12'h777};
        tv[5] = '{100, 50, 12'h321, 12'h321};
        tv[6] = '{105, 82, 12'h654, 12'h654};
        tv[7] = '{131, 50, 12'h111, 12'h0A1};
        for (int i = 0; i < 8; i++)
            pix($sformatf("vec%0d", i), int'(tv[i].vx), int'(tv[i].vy), tv[i].si, tv[i].exp);

        wr(ra(0, 0), 32'h3);
        pix("hflip", 100, 50, 12'h222, 12'h0A1);
        wr(ra(0, 0), 32'h7);
        pix("hvflip", 100, 50, 12'h222, 12'h0B2);

        // Priority and transparency with sprites 0 and 1 stacked.
        wr(ra(0, 0), 32'h1);
        wr(ra(0, 1), 200);
        wr(ra(0, 2), 200);
        wr(pa(0, 0, 0), 32'h0F0);
        wr(pa(1, 0, 0), 32'h00F);
        wr(ra(1, 1), 200);
        wr(ra(1, 2), 200);
        wr(ra(1, 0), 32'h1);
        pix("prio", 200, 200, 12'h333, 12'h0F0);
        wr(pa(0, 0, 0), 32'h000);
        pix("key_reveal", 200, 200, 12'h333, 12'h00F);
        pix("both_key", 201, 200, 12'h334, 12'h334);
        wr(pa(4, 0, 0), 32'h777);
        pix("oob_sprite", 200, 200, 12'h333, 12'h00F);

        // Motion: sprite 2 wraps in X, sprite 3 (disabled) wraps in Y.
        wr(pa(2, 0, 0), 32'hABC);
        wr(ra(2, 1), 630);
        wr(ra(2, 2), 100);
        wr(ra(2, 3), 20);
        wr(ra(2, 0), 32'h9);
        wr(pa(3, 0, 0), 32'hDEF);
        wr(ra(3, 1), 400);
        wr(ra(3, 2), 5);
        wr(ra(3, 4), 32'hF8);
        wr(ra(3, 0), 32'h8);
        pix("clip_no_wrap", 5, 100, 12'h444, 12'h444);
        pix("pre_move", 630, 100, 12'h444, 12'hABC);
        tick_frame();
        pix("x_wrapped", 10, 100, 12'h445, 12'hABC);
        pix("x_old_pos", 630, 100, 12'h446, 12'h446);
        wr(ra(3, 0), 32'h9);
        pix("y_wrapped", 400, 477, 12'h447, 12'hDEF);

        // CPU x0 write lands in the tick cycle; y0 still moves.
        wr(ra(2, 4), 4);
        @(negedge clk);
        x = 11'd0; y = 11'd480;
        cs = 1'b1; write = 1'b1; addr = ra(2, 1); wr_data = 300;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; x = 11'd1000; y = 11'd1000;
        pix("collide_cpu_x", 300, 104, 12'h448, 12'hABC);
        pix("collide_old_y", 300, 100, 12'h449, 12'h449);
        pix("collide_no_mv", 30, 104, 12'h44A, 12'h44A);
        pix("y_second_tick", 400, 469, 12'h44B, 12'hDEF);

        // Exact 2-clock latency on a one-cycle hit between misses.
        hist.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 2) chk($sformatf("lat%0d", k), so_rgb, hist[k - 2]);
            if (k[0]) begin
                x = 11'd299; si_rgb = 12'(k + 16); hist.push_back(12'(k + 16));
            end else begin
                x = 11'd300; si_rgb = 12'(k + 16); hist.push_back(12'hABC);
            end
            y = 11'd104;
        end

        // Bypass via a global write through an out-of-range sprite index.
        wr(ra(5, 7), 32'h1);
        hist.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) chk($sformatf("byp%0d", k), so_rgb, hist[k - 2]);
            x = 11'd300; y = 11'd104; si_rgb = 12'(12'h5A0 + k);
            hist.push_back(12'(12'h5A0 + k));
        end
        wr(ra(0, 7), 32'h0);

        // Reset mid-output clears pipeline and registers, keeps pattern RAM.
        pix("pre_reset", 300, 104, 12'h555, 12'hABC);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 chk("reset_edge", so_rgb, 12'h000);
        @(negedge clk);
        reset = 1'b0; si_rgb = 12'h9C9;
        @(negedge clk);
        chk("post_reset_1", so_rgb, 12'h000);
        @(negedge clk);
        chk("post_reset_2", so_rgb, 12'h9C9);
        pix("regs_cleared", 300, 104, 12'h556, 12'h556);
        pix("bypass_cleared", 0, 0, 12'h557, 12'h557);
        wr(ra(2, 1), 300);
        wr(ra(2, 2), 104);
        wr(ra(2, 0), 32'h1);
        pix("ram_retained", 300, 104, 12'h558, 12'hABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
